// File: rtl/scan_endpoint.sv
// rtl/scan_endpoint.sv - scan chain endpoint with synchronized scan inputs
//
// Purpose:
//   Receives a serial scan stream from an asynchronous scan controller,
//   shifts it through a WIDTH-bit register and latches complete frames onto
//   the project inputs. In capture mode the project outputs are loaded into
//   the same register so they can be shifted out toward the next element.
//
// Ports:
//   clk           system clock, all state updates on its rising edge
//   reset         asynchronous active-high reset
//   sc_clk_in     scan clock (async to clk)
//   sc_data_in    serial scan data, MSB first (async to clk)
//   sc_select_in  1 = capture, 0 = shift (async to clk)
//   sc_latch_in   latch strobe (async to clk)
//   sc_data_out   registered MSB of the shift register
//   proj_out      project outputs, loaded on a capture event
//   proj_in       latched project inputs
//   proj_valid    one-cycle pulse per accepted latch
//   framing_err   sticky, set when a latch arrives on an incomplete frame

module scan_endpoint #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sc_clk_in,
  input  logic             sc_data_in,
  input  logic             sc_select_in,
  input  logic             sc_latch_in,
  output logic             sc_data_out,
  input  logic [WIDTH-1:0] proj_out,
  output logic [WIDTH-1:0] proj_in,
  output logic             proj_valid,
  output logic             framing_err
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

  // Index 0 is the first flop seen by the async input; the top index is the
  // synchronized value used by the logic.
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic [SYNC_STAGES-1:0] select_sync;
  logic [SYNC_STAGES-1:0] latch_sync;

  logic clk_s;
  logic data_s;
  logic select_s;
  logic latch_s;

  logic clk_dly;
  logic latch_dly;

  logic clk_rise;
  logic latch_rise;

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             latch_ok;
  logic             latch_bad;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync    <= '0;
      data_sync   <= '0;
      select_sync <= '0;
      latch_sync  <= '0;
    end else begin
      clk_sync    <= {clk_sync[SYNC_STAGES-2:0], sc_clk_in};
      data_sync   <= {data_sync[SYNC_STAGES-2:0], sc_data_in};
      select_sync <= {select_sync[SYNC_STAGES-2:0], sc_select_in};
      latch_sync  <= {latch_sync[SYNC_STAGES-2:0], sc_latch_in};
    end
  end

  assign clk_s    = clk_sync[SYNC_STAGES-1];
  assign data_s   = data_sync[SYNC_STAGES-1];
  assign select_s = select_sync[SYNC_STAGES-1];
  assign latch_s  = latch_sync[SYNC_STAGES-1];

  // Delayed copies reset to 0, so a scan input already high when reset is
  // released still yields one event once it has crossed the synchronizer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_dly   <= 1'b0;
      latch_dly <= 1'b0;
    end else begin
      clk_dly   <= clk_s;
      latch_dly <= latch_s;
    end
  end

  assign clk_rise   = clk_s & ~clk_dly;
  assign latch_rise = latch_s & ~latch_dly;

  // Shift/capture is resolved first so a latch in the same cycle sees the
  // register and bit count including this cycle's bit.
  always_comb begin
    sr_next  = sr;
    cnt_next = cnt;
    if (clk_rise) begin
      if (select_s) begin
        sr_next  = proj_out;
        cnt_next = '0;
      end else begin
        sr_next = {sr[WIDTH-2:0], data_s};
        // Saturating count: extra shifts are legal, the latch then takes the
        // most recent WIDTH bits.
        if (cnt != CNT_FULL) begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
    end
  end

  assign latch_ok  = latch_rise & (cnt_next == CNT_FULL);
  assign latch_bad = latch_rise & (cnt_next != CNT_FULL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr          <= '0;
      cnt         <= '0;
      proj_in     <= '0;
      proj_valid  <= 1'b0;
      framing_err <= 1'b0;
      sc_data_out <= 1'b0;
    end else begin
      sr          <= sr_next;
      cnt         <= latch_rise ? '0 : cnt_next;
      proj_valid  <= latch_ok;
      // Registered copy of the next MSB keeps sc_data_out equal to sr's MSB
      // every cycle with no combinational path from any input.
      sc_data_out <= sr_next[WIDTH-1];
      if (latch_ok) begin
        proj_in <= sr_next;
      end
      if (latch_bad) begin
        framing_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_scan_endpoint.sv
// tb/tb_scan_endpoint.sv - randomized self-checking bench for scan_endpoint

module tb_scan_endpoint;

  localparam int W = 8;
  localparam int S = 2;
  localparam int H = S + 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         sc_clk_in = 1'b0;
  logic         sc_data_in = 1'b0;
  logic         sc_select_in = 1'b0;
  logic         sc_latch_in = 1'b0;
  logic         sc_data_out;
  logic [W-1:0] proj_out = '0;
  logic [W-1:0] proj_in;
  logic         proj_valid;
  logic         framing_err;

  scan_endpoint #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk         (clk),
    .reset       (reset),
    .sc_clk_in   (sc_clk_in),
    .sc_data_in  (sc_data_in),
    .sc_select_in(sc_select_in),
    .sc_latch_in (sc_latch_in),
    .sc_data_out (sc_data_out),
    .proj_out    (proj_out),
    .proj_in     (proj_in),
    .proj_valid  (proj_valid),
    .framing_err (framing_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int cyc;
    bit is_latch;
    bit d;
    bit sel;
  } ev_t;

  ev_t evq[$];

  int m_sr = 0;
  int m_cnt = 0;
  int m_pi = 0;
  bit m_fe = 0;
  bit m_pv = 0;

  int n_checks = 0;
  int n_fail = 0;
  int pv_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Scoreboard: replays each scan event at the clk cycle it must take effect
  // and compares every DUT output once per cycle.
  always @(negedge clk) begin
    m_pv = 0;
    if (reset) begin
      m_sr = 0; m_cnt = 0; m_pi = 0; m_fe = 0;
      evq.delete();
    end else begin
      while (evq.size() > 0 && evq[0].cyc <= cyc) begin
        ev_t e;
        e = evq.pop_front();
        if (!e.is_latch) begin
          if (e.sel) begin
            m_sr = int'(proj_out);
            m_cnt = 0;
          end else begin
            m_sr = ((m_sr * 2) + int'(e.d)) % (1 << W);
            m_cnt = (m_cnt + 1 > W) ? W : m_cnt + 1;
          end
        end else begin
          if (m_cnt == W) begin
            m_pi = m_sr;
            m_pv = 1;
          end else begin
            m_fe = 1;
          end
          m_cnt = 0;
        end
      end
    end
    if (proj_valid === 1'b1) pv_seen++;
    chk("proj_in", 32'(proj_in), 32'(m_pi));
    chk("proj_valid", 32'(proj_valid), 32'(m_pv));
    chk("framing_err", 32'(framing_err), 32'(m_fe));
    chk("sc_data_out", 32'(sc_data_out), 32'((m_sr >> (W - 1)) & 1));
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One scan pulse on sc_clk and/or sc_latch with phases long enough to
  // always register; the expected event cycle is recorded for the scoreboard.
  task automatic pulse(input bit do_clk, input bit do_latch, input bit d,
                       input bit sel, input logic [W-1:0] po);
    ev_t e;
    wait_cyc(1);
    proj_out = po;
    sc_data_in = d;
    sc_select_in = sel;
    wait_cyc(H);
    sc_clk_in = do_clk;
    sc_latch_in = do_latch;
    e.cyc = cyc + S + 1;
    e.d = d;
    e.sel = sel;
    if (do_clk) begin
      e.is_latch = 0;
      evq.push_back(e);
    end
    if (do_latch) begin
      e.is_latch = 1;
      evq.push_back(e);
    end
    wait_cyc(H);
    sc_clk_in = 1'b0;
    sc_latch_in = 1'b0;
    wait_cyc(H);
  endtask

  task automatic shift_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) pulse(1, 0, v[i], 0, W'($urandom));
  endtask

  task automatic latch();
    pulse(0, 1, 0, 0, W'($urandom));
  endtask

  task automatic do_reset();
    wait_cyc(1);
    reset = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(2);
  endtask

  initial begin
    int pv0;
    logic [6:0] seq;
    reset = 1'b1;
    wait_cyc(3);
    chk("reset_proj_in", 32'(proj_in), 32'h0);
    chk("reset_dout", 32'(sc_data_out), 32'h0);
    reset = 1'b0;
    wait_cyc(2);

    // 0xA5 frame
    pv0 = pv_seen;
    shift_bits(16'hA5, 8);
    latch();
    chk("a5_proj_in", 32'(proj_in), 32'hA5);
    chk("a5_pv_count", 32'(pv_seen - pv0), 32'd1);
    chk("a5_ferr", 32'(framing_err), 32'h0);

    // short frame, then a good 0x5A frame
    pv0 = pv_seen;
    shift_bits(16'h1F, 5);
    latch();
    chk("short_ferr", 32'(framing_err), 32'h1);
    chk("short_proj_in", 32'(proj_in), 32'hA5);
    chk("short_pv_count", 32'(pv_seen - pv0), 32'd0);
    shift_bits(16'h5A, 8);
    latch();
    chk("5a_proj_in", 32'(proj_in), 32'h5A);

    // 7 shifts then clock and latch rising together: 8th bit included
    pv0 = pv_seen;
    shift_bits(16'h61, 7);
    pulse(1, 1, 1, 0, W'($urandom));
    chk("simul_proj_in", 32'(proj_in), 32'hC3);
    chk("simul_pv_count", 32'(pv_seen - pv0), 32'd1);

    // capture 0x3C and shift it out
    pulse(1, 0, 0, 1, 8'h3C);
    chk("cap_dout0", 32'(sc_data_out), 32'h0);
    seq = 7'b0111100;
    for (int i = 0; i < 7; i++) begin
      pulse(1, 0, 1'($urandom), 0, W'($urandom));
      chk("cap_dout_seq", 32'(sc_data_out), 32'(seq[6-i]));
    end
    latch();

    // 12 shifts, latch takes the last 8
    shift_bits(16'h0F0, 12);
    latch();
    chk("long_proj_in", 32'(proj_in), 32'hF0);

    // reset mid-frame, then a full 0xFF frame
    shift_bits(16'hF, 4);
    wait_cyc(1);
    reset = 1'b1;
    wait_cyc(2);
    chk("rst_proj_in", 32'(proj_in), 32'h0);
    chk("rst_pv", 32'(proj_valid), 32'h0);
    chk("rst_ferr", 32'(framing_err), 32'h0);
    chk("rst_dout", 32'(sc_data_out), 32'h0);
    reset = 1'b0;
    wait_cyc(2);
    shift_bits(16'hFF, 8);
    latch();
    chk("ff_proj_in", 32'(proj_in), 32'hFF);
    chk("ff_ferr", 32'(framing_err), 32'h0);

    // random traffic against the scoreboard
    for (int n = 0; n < 400; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 70)      pulse(1, 0, 1'($urandom), 0, W'($urandom));
      else if (r < 78) pulse(1, 0, 1'($urandom), 1, W'($urandom));
      else if (r < 92) latch();
      else if (r < 98) pulse(1, 1, 1'($urandom), 0, W'($urandom));
      else             do_reset();
    end
    wait_cyc(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
